seq_stream_ctrl: RTL and testbench

Controller that shares one serial pattern-detect datapath between two requesters. Each requester submits a 16-bit word. A round-robin arbiter grants one requester at a time. The granted word is streamed LSB-first through an internal overlapping pattern detector, and the block reports the number of pattern hits when the word finishes. It sits in front of the sequence-detector FSM and is the block that sequences it and shares it between requesters.

---
 rtl/seq_stream_ctrl.sv | 130 +++++++++++++
 tb/tb_seq_stream_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_ctrl.sv
// ============================================================================
// seq_stream_ctrl : two-requester round-robin front end that streams a word
// LSB-first through an overlapping serial pattern detector and counts hits.
// Optional feature macro: SEQ_STREAM_CTRL_ABORT_EN (adds abort_i).
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module seq_stream_ctrl #(
  parameter int                 WIDTH   = 16,
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req0_i,
  input  logic                       req1_i,
  input  logic [WIDTH-1:0]           word0_i,
  input  logic [WIDTH-1:0]           word1_i,
`ifdef SEQ_STREAM_CTRL_ABORT_EN
  input  logic                       abort_i,
`endif
  output logic                       gnt0_o,
  output logic                       gnt1_o,
  output logic                       busy_o,
  output logic                       bit_out_o,
  output logic                       bit_valid_o,
  output logic                       match_o,
  output logic                       done_o,
  output logic                       done_id_o,
  output logic [$clog2(WIDTH+1)-1:0] match_cnt_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   word_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PAT_LEN-2:0] win_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               owner_q;
  logic               last_q;
  logic               gnt0_q;
  logic               gnt1_q;

  logic               bit_d;
  logic [PAT_LEN-1:0] shift_d;
  logic               hit_d;
  logic               sel_d;
  logic               abort_d;

  assign bit_d   = (state_q == SHIFT) ? word_q[idx_q] : 1'b0;
  assign shift_d = {win_q, bit_d};
  // The index guard suppresses hits before a full pattern has arrived.
  assign hit_d   = (state_q == SHIFT) && (shift_d == PATTERN) &&
                   (idx_q >= IDX_W'(PAT_LEN-1));
  assign sel_d   = (req0_i && req1_i) ? ~last_q : req1_i;

`ifdef SEQ_STREAM_CTRL_ABORT_EN
  assign abort_d = abort_i;
`else
  assign abort_d = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0_i || req1_i) begin
            word_q  <= sel_d ? word1_i : word0_i;
            gnt0_q  <= ~sel_d;
            gnt1_q  <= sel_d;
            owner_q <= sel_d;
            last_q  <= sel_d;
            idx_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort_d) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            win_q <= shift_d[PAT_LEN-2:0];
            if (hit_d) cnt_q <= cnt_q + CNT_W'(1);
            if (idx_q == IDX_W'(WIDTH-1)) state_q <= DONE;
            else                          idx_q   <= idx_q + IDX_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign busy_o      = (state_q != IDLE);
  assign bit_out_o   = bit_d;
  assign bit_valid_o = (state_q == SHIFT);
  assign match_o     = hit_d;
  assign done_o      = (state_q == DONE);
  assign done_id_o   = (state_q == DONE) && owner_q;
  assign match_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_stream_ctrl.sv
// Directed bench for seq_stream_ctrl with a grant-ordered scoreboard and a
// bit-level reference model of the pattern detector.
`default_nettype none
`timescale 1ns/1ps

module tb_seq_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] word0, word1;
  logic        gnt0, gnt1, busy, bit_out, bit_valid, match, done, done_id;
  logic [4:0]  match_cnt;
`ifdef SEQ_STREAM_CTRL_ABORT_EN
  logic        abort;
`endif

  always #5 clk = ~clk;

  seq_stream_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req0_i      (req0),
    .req1_i      (req1),
    .word0_i     (word0),
    .word1_i     (word1),
`ifdef SEQ_STREAM_CTRL_ABORT_EN
    .abort_i     (abort),
`endif
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .busy_o      (busy),
    .bit_out_o   (bit_out),
    .bit_valid_o (bit_valid),
    .match_o     (match),
    .done_o      (done),
    .done_id_o   (done_id),
    .match_cnt_o (match_cnt)
  );

  typedef struct {
    logic        id;
    logic [15:0] word;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // monitor state
  int       cyc = 0;
  int       t_gnt0 = 0, t_gnt1 = 0;
  int       done_seen = 0, gnt0_seen = 0;
  logic     mon_active = 1'b0;
  exp_t     cur;
  int       m_idx, m_cnt;
  logic [2:0] m_win;
  logic     eb, em;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(input logic id, input string tag);
    logic seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      #1;
      seen = id ? gnt1 : gnt0;
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      #1;
      seen = done;
    end
    chk(tag, seen, 1);
  endtask

  function automatic logic [12:0] all_out();
    return {gnt0, gnt1, busy, bit_out, bit_valid, match, done, done_id, match_cnt};
  endfunction

  // Scoreboard consumer: pops at each grant, models every streamed bit.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (gnt0 || gnt1) begin
          if (gnt0) begin t_gnt0 = cyc; gnt0_seen++; end
          if (gnt1) t_gnt1 = cyc;
          chk("gnt_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("gnt_id", {gnt1, gnt0}, cur.id ? 2'b10 : 2'b01);
          end
          mon_active = 1'b1;
          m_idx = 0;
          m_cnt = 0;
          m_win = 3'b000;
        end
        if (bit_valid) begin
          chk("bit_active", mon_active, 1);
          eb = cur.word[m_idx];
          em = ({m_win, eb} == 4'b1011) && (m_idx >= 3);
          chk("bit_out", bit_out, eb);
          chk("match", match, em);
          chk("busy_shift", busy, 1);
          m_win = {m_win[1:0], eb};
          if (em) m_cnt++;
          m_idx++;
        end
        if (done) begin
          done_seen++;
          chk("done_active", mon_active, 1);
          chk("done_len", m_idx, 16);
          chk("done_id", done_id, cur.id);
          chk("match_cnt_model", match_cnt, m_cnt);
          chk("match_cnt_plan", match_cnt, cur.cnt);
          chk("busy_done", busy, 1);
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    int d, g;
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    word0 = '0;
    word1 = '0;
`ifdef SEQ_STREAM_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    step(3);
    chk("reset_outputs", all_out(), 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_after_reset", all_out(), 0);

    // single word from requester 0
    word0 = 16'hB6DB;
    req0  = 1'b1;
    exp_q.push_back('{1'b0, 16'hB6DB, 4});
    wait_gnt(1'b0, "t1_gnt0");
    req0 = 1'b0;
    wait_done("t1_done");
    step(1);
    chk("t1_idle_busy", busy, 0);

    // tie from reset, spacing between grants
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    word0 = 16'h0000;
    word1 = 16'hDDDD;
    exp_q.push_back('{1'b0, 16'h0000, 0});
    exp_q.push_back('{1'b1, 16'hDDDD, 4});
    req0 = 1'b1;
    req1 = 1'b1;
    wait_gnt(1'b0, "t2_gnt0");
    req0 = 1'b0;
    wait_gnt(1'b1, "t2_gnt1");
    req1 = 1'b0;
    chk("t2_gnt_spacing", t_gnt1 - t_gnt0, 18);
    wait_done("t2_done");

    // requester 1 alone, three back-to-back words
    g = gnt0_seen;
    word1 = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      req1 = 1'b1;
      exp_q.push_back('{1'b1, 16'hFFFF, 0});
      wait_gnt(1'b1, "t3_gnt1");
      req1 = 1'b0;
      wait_done("t3_done");
    end
    chk("t3_no_gnt0", gnt0_seen, g);

    // reset in the middle of a word owned by requester 0
    step(1);
    word0 = 16'hB6DB;
    req0  = 1'b1;
    exp_q.push_back('{1'b0, 16'hB6DB, 4});
    wait_gnt(1'b0, "t4_gnt0");
    req0 = 1'b0;
    step(8);
    chk("t4_idx8_valid", bit_valid, 1);
    d = done_seen;
    rst_n = 1'b0;
    mon_active = 1'b0;
    #1;
    chk("t4_rst_outputs", all_out(), 0);
    step(3);
    chk("t4_rst_hold", all_out(), 0);
    rst_n = 1'b1;
    step(3);
    chk("t4_no_done", done_seen, d);
    word0 = 16'hDDDD;
    word1 = 16'hB6DB;
    exp_q.push_back('{1'b0, 16'hDDDD, 4});
    exp_q.push_back('{1'b1, 16'hB6DB, 4});
    req0 = 1'b1;
    req1 = 1'b1;
    wait_gnt(1'b0, "t4_tie_gnt0");
    req0 = 1'b0;
    wait_gnt(1'b1, "t4_tie_gnt1");
    req1 = 1'b0;
    wait_done("t4_done");

`ifdef SEQ_STREAM_CTRL_ABORT_EN
    // abort at idx 5 while requester 1 waits
    step(1);
    word0 = 16'hB6DB;
    word1 = 16'hDDDD;
    req0  = 1'b1;
    exp_q.push_back('{1'b0, 16'hB6DB, 4});
    wait_gnt(1'b0, "t5_gnt0");
    req0 = 1'b0;
    req1 = 1'b1;
    exp_q.push_back('{1'b1, 16'hDDDD, 4});
    step(5);
    chk("t5_cnt_before_abort", match_cnt, 1);
    d = done_seen;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    mon_active = 1'b0;
    chk("t5_valid_dropped", bit_valid, 0);
    chk("t5_cnt_cleared", match_cnt, 0);
    step(1);
    chk("t5_gnt1_next_sample", gnt1, 1);
    chk("t5_no_done", done_seen, d);
    req1 = 1'b0;
    wait_done("t5_done");
`endif

    step(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
